// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared LC-3b types for the issue/hazard controller.
//   lc3b_reg      : 3-bit architectural register index (R0..R7)
//   issue_state_t : issue FSM states (RUN, BR_WAIT, FLUSH)
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } issue_state_t;

endpackage

// File: rtl/issue_hazard_ctrl_sat_counter16.sv
// Saturating 16-bit event counter.
//   clk   : clock, count updates on posedge
//   reset : asynchronous active-high clear
//   inc   : add one this cycle (ignored once the counter reaches 16'hFFFF)
//   count : current count
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/issue_hazard_ctrl.sv
// In-order issue control with scoreboard hazard detection and branch wait/flush.
//   clk, reset             : clock and asynchronous active-high reset
//   valid_in               : decoded instruction present
//   src1/src2, *_use       : source registers and whether each is read
//   dest, dest_write       : destination register and whether it is written
//   is_branch              : instruction is control flow
//   br_resolved, br_taken  : outstanding branch resolved this cycle / was taken
//   mem_miss               : cache miss pending, freezes issue and branch countdown
//   sb_ready               : per-register value-available bits
//   issue, issue_dest      : instruction issues this cycle / its destination
//   stall                  : hold fetch/decode
//   flush                  : squash younger instructions (registered)
//   br_stall_count         : branch-wait counter
//   stall_cycles           : saturating count of stalled cycles
module issue_hazard_ctrl
    import lc3b_types::*;
#(
    parameter logic [1:0] BR_STALL_INIT = 2'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  lc3b_reg     src1,
    input  lc3b_reg     src2,
    input  logic        src1_use,
    input  logic        src2_use,
    input  lc3b_reg     dest,
    input  logic        dest_write,
    input  logic        is_branch,
    input  logic        br_resolved,
    input  logic        br_taken,
    input  logic        mem_miss,
    input  logic [7:0]  sb_ready,
    output logic        issue,
    output lc3b_reg     issue_dest,
    output logic        stall,
    output logic        flush,
    output logic [1:0]  br_stall_count,
    output logic [15:0] stall_cycles
);

    issue_state_t state_q;
    logic [1:0]   br_cnt_q;
    logic         flush_q;
    logic         hazard;

    // RAW on either source, WAW on the destination.
    always_comb begin
        hazard = (src1_use   & ~sb_ready[src1]) |
                 (src2_use   & ~sb_ready[src2]) |
                 (dest_write & ~sb_ready[dest]);
    end

    always_comb begin
        issue = (state_q == RUN) & valid_in & ~hazard & ~mem_miss & ~reset;
        stall = (state_q != RUN) | (valid_in & ~issue);
    end

    assign issue_dest     = dest;
    assign flush          = flush_q;
    assign br_stall_count = br_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            br_cnt_q <= 2'd0;
            flush_q  <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    // br_resolved here belongs to an older branch and is ignored.
                    if (issue && is_branch) begin
                        state_q  <= BR_WAIT;
                        br_cnt_q <= BR_STALL_INIT;
                    end
                end
                BR_WAIT: begin
                    if (br_resolved) begin
                        br_cnt_q <= 2'd0;
                        if (br_taken) begin
                            state_q <= FLUSH;
                            flush_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else if (!mem_miss && (br_cnt_q != 2'd0)) begin
                        br_cnt_q <= br_cnt_q - 2'd1;
                    end
                end
                FLUSH: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q  <= RUN;
                    br_cnt_q <= 2'd0;
                end
            endcase
        end
    end

    sat_counter16 u_stall_stat (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
module tb_issue_hazard_ctrl;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    lc3b_reg     src1, src2, dest;
    logic        src1_use, src2_use, dest_write;
    logic        is_branch, br_resolved, br_taken, mem_miss;
    logic [7:0]  sb_ready;
    logic        issue;
    lc3b_reg     issue_dest;
    logic        stall, flush;
    logic [1:0]  br_stall_count;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // Reference model: a pending-branch flag with a wait countdown, a
    // one-cycle flush flag, and a plain integer stall statistic.
    bit m_wait;
    bit m_flush;
    int m_cnt;
    int m_stat;

    issue_hazard_ctrl #(.BR_STALL_INIT(2'd3)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .src1           (src1),
        .src2           (src2),
        .src1_use       (src1_use),
        .src2_use       (src2_use),
        .dest           (dest),
        .dest_write     (dest_write),
        .is_branch      (is_branch),
        .br_resolved    (br_resolved),
        .br_taken       (br_taken),
        .mem_miss       (mem_miss),
        .sb_ready       (sb_ready),
        .issue          (issue),
        .issue_dest     (issue_dest),
        .stall          (stall),
        .flush          (flush),
        .br_stall_count (br_stall_count),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit reg_ready(input logic [7:0] sb, input int r);
        return ((sb >> r) & 8'd1) != 8'd0;
    endfunction

    function automatic bit model_hazard();
        return (src1_use && !reg_ready(sb_ready, int'(src1))) ||
               (src2_use && !reg_ready(sb_ready, int'(src2))) ||
               (dest_write && !reg_ready(sb_ready, int'(dest)));
    endfunction

    task automatic model_clear();
        m_wait = 0; m_flush = 0; m_cnt = 0; m_stat = 0;
    endtask

    task automatic idle_inputs();
        valid_in = 0; src1 = 0; src2 = 0; dest = 0;
        src1_use = 0; src2_use = 0; dest_write = 0;
        is_branch = 0; br_resolved = 0; br_taken = 0; mem_miss = 0;
        sb_ready = 8'hFF;
    endtask

    // Called just after a posedge with inputs set; checks mid-cycle, then
    // advances the model across the next edge.
    task automatic cycle_check(input string tag);
        bit e_issue, e_stall;
        @(negedge clk);
        e_issue = !m_wait && !m_flush && valid_in && !model_hazard() && !mem_miss && !reset;
        e_stall = m_wait || m_flush || (valid_in && !e_issue);
        total++;
        if (issue !== e_issue) begin
            bad++; $display("FAIL %s issue: got %b want %b", tag, issue, e_issue);
        end
        total++;
        if (issue_dest !== dest) begin
            bad++; $display("FAIL %s issue_dest: got %0d want %0d", tag, issue_dest, dest);
        end
        total++;
        if (stall !== e_stall) begin
            bad++; $display("FAIL %s stall: got %b want %b", tag, stall, e_stall);
        end
        total++;
        if (flush !== m_flush) begin
            bad++; $display("FAIL %s flush: got %b want %b", tag, flush, m_flush);
        end
        total++;
        if (int'(br_stall_count) != m_cnt) begin
            bad++; $display("FAIL %s br_stall_count: got %0d want %0d", tag, br_stall_count, m_cnt);
        end
        total++;
        if (int'(stall_cycles) != m_stat) begin
            bad++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, m_stat);
        end
        if (!reset) begin
            if (e_stall && m_stat < 65535) m_stat++;
            if (m_flush) begin
                m_flush = 0;
            end else if (m_wait) begin
                if (br_resolved) begin
                    m_wait = 0; m_cnt = 0; m_flush = br_taken;
                end else if (!mem_miss && m_cnt > 0) begin
                    m_cnt--;
                end
            end else if (e_issue && is_branch) begin
                m_wait = 1; m_cnt = 3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_clear();
    endtask

    task automatic test_reset();
        idle_inputs();
        valid_in = 1;
        reset = 1;
        #2;
        total++;
        if (issue !== 1'b0 || flush !== 1'b0 || br_stall_count !== 2'd0 || stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs: got issue=%b flush=%b cnt=%0d stat=%0d want all 0",
                     issue, flush, br_stall_count, stall_cycles);
        end
        do_reset();
        cycle_check("reset_idle");
    endtask

    task automatic test_basic_issue();
        do_reset();
        valid_in = 1; src1 = 3'd2; src1_use = 1; dest = 3'd3; dest_write = 1; sb_ready = 8'hFF;
        #1;
        total++;
        if (issue !== 1'b1 || issue_dest !== 3'd3 || stall !== 1'b0) begin
            bad++;
            $display("FAIL basic_issue: got issue=%b dest=%0d stall=%b want 1 3 0",
                     issue, issue_dest, stall);
        end
        cycle_check("basic_issue");
    endtask

    task automatic test_raw_stall();
        int s0;
        do_reset();
        valid_in = 1; src1 = 3'd2; src1_use = 1; dest = 3'd3; dest_write = 1; sb_ready = 8'hFB;
        #1;
        s0 = int'(stall_cycles);
        total++;
        if (issue !== 1'b0 || stall !== 1'b1) begin
            bad++; $display("FAIL raw_stall: got issue=%b stall=%b want 0 1", issue, stall);
        end
        repeat (3) cycle_check("raw_stall");
        total++;
        if (int'(stall_cycles) != s0 + 3) begin
            bad++; $display("FAIL raw_stall_count: got %0d want %0d", stall_cycles, s0 + 3);
        end
        sb_ready = 8'hFF;
        #1;
        total++;
        if (issue !== 1'b1) begin
            bad++; $display("FAIL raw_release: got issue=%b want 1", issue);
        end
        cycle_check("raw_release");
    endtask

    task automatic test_branch_taken();
        int exp_cnt[5] = '{3, 2, 1, 0, 0};
        do_reset();
        valid_in = 1; is_branch = 1; dest = 3'd7;
        cycle_check("br_issue");
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (int'(br_stall_count) != exp_cnt[i] || stall !== 1'b1) begin
                bad++;
                $display("FAIL br_count[%0d]: got cnt=%0d stall=%b want %0d 1",
                         i, br_stall_count, stall, exp_cnt[i]);
            end
            cycle_check("br_wait");
        end
        br_resolved = 1; br_taken = 1;
        cycle_check("br_resolve_taken");
        br_resolved = 0; br_taken = 0;
        #1;
        total++;
        if (flush !== 1'b1) begin
            bad++; $display("FAIL br_flush: got %b want 1", flush);
        end
        cycle_check("br_flush");
        #1;
        total++;
        if (flush !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL br_after_flush: got flush=%b stall=%b want 0 0", flush, stall);
        end
        cycle_check("br_back_run");
    endtask

    task automatic test_branch_miss();
        do_reset();
        valid_in = 1; is_branch = 1;
        br_resolved = 1; br_taken = 1;   // resolution of an older branch: ignored
        cycle_check("miss_br_issue");
        idle_inputs();
        mem_miss = 1;
        repeat (2) cycle_check("miss_hold");
        #1;
        total++;
        if (br_stall_count !== 2'd3) begin
            bad++; $display("FAIL miss_hold_count: got %0d want 3", br_stall_count);
        end
        br_resolved = 1; br_taken = 0;
        cycle_check("miss_resolve");
        idle_inputs();
        #1;
        total++;
        if (br_stall_count !== 2'd0 || flush !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL miss_exit: got cnt=%0d flush=%b stall=%b want 0 0 0",
                     br_stall_count, flush, stall);
        end
        cycle_check("miss_run");
    endtask

    task automatic test_saturate();
        do_reset();
        valid_in = 1; src1 = 3'd5; src1_use = 1; sb_ready = 8'hDF;
        repeat (65534) @(posedge clk);
        #1;
        total++;
        if (stall_cycles !== 16'hFFFE) begin
            bad++; $display("FAIL sat_near: got %h want fffe", stall_cycles);
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (stall_cycles !== 16'hFFFF) begin
            bad++; $display("FAIL sat_hold: got %h want ffff", stall_cycles);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        valid_in = 1; is_branch = 1;
        cycle_check("ar_br_issue");
        idle_inputs();
        valid_in = 1;
        cycle_check("ar_wait");
        #2;
        reset = 1;
        #1;
        total++;
        if (issue !== 1'b0 || flush !== 1'b0 || br_stall_count !== 2'd0 || stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL async_reset: got issue=%b flush=%b cnt=%0d stat=%0d want all 0",
                     issue, flush, br_stall_count, stall_cycles);
        end
        #1;
        reset = 0;
        model_clear();
        idle_inputs();
        repeat (2) cycle_check("ar_post");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            valid_in    = ($urandom_range(0, 3) != 0);
            src1        = lc3b_reg'($urandom_range(0, 7));
            src2        = lc3b_reg'($urandom_range(0, 7));
            dest        = lc3b_reg'($urandom_range(0, 7));
            src1_use    = $urandom_range(0, 1) != 0;
            src2_use    = $urandom_range(0, 1) != 0;
            dest_write  = $urandom_range(0, 1) != 0;
            is_branch   = ($urandom_range(0, 2) == 0);
            br_resolved = ($urandom_range(0, 3) == 0);
            br_taken    = $urandom_range(0, 1) != 0;
            mem_miss    = ($urandom_range(0, 4) == 0);
            sb_ready    = 8'($urandom | $urandom);
            cycle_check("random");
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        model_clear();
        #12;
        test_reset();
        test_basic_issue();
        test_raw_stall();
        test_branch_taken();
        test_branch_miss();
        test_async_reset();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_hazard_ctrl.md
ISSUE_HAZARD_CTRL -- requirements
Module: issue_hazard_ctrl

Interface
REQ-001 SHALL have parameter BR_STALL_INIT, default 2'd3, value loaded into br_stall_count when a control-flow instruction issues.
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid_in  input  1  decoded instruction present in decode stage.
REQ-005 SHALL have ports src1, src2  input  lc3b_reg  source register indices; src1_use, src2_use  input  1  source actually read.
REQ-006 SHALL have ports dest  input  lc3b_reg  destination index; dest_write  input  1  instruction writes dest.
REQ-007 SHALL have port is_branch  input  1  instruction is control flow (BR/JMP/JSR/TRAP).
REQ-008 SHALL have ports br_resolved, br_taken  input  1  branch resolved this cycle; taken qualifies resolved.
REQ-009 SHALL have port mem_miss  input  1  any cache miss pending; freezes pipeline.
REQ-010 SHALL have port sb_ready  input  8  scoreboard bits, 1 = register value available.
REQ-011 SHALL have outputs issue  1  (drives scoreboard write0), issue_dest  lc3b_reg  (drives scoreboard index0), stall  1  hold fetch/decode.
REQ-012 SHALL have outputs flush  1  squash younger instructions, br_stall_count  2  branch-wait counter, stall_cycles  16  saturating stall statistic.

Function
REQ-013 SHALL compute hazard = (src1_use & !sb_ready[src1]) | (src2_use & !sb_ready[src2]) | (dest_write & !sb_ready[dest]) (RAW and WAW).
REQ-014 SHALL implement FSM states RUN, BR_WAIT, FLUSH.
REQ-015 SHALL assert issue combinationally iff state==RUN & valid_in & !hazard & !mem_miss & !reset; issue_dest SHALL equal dest at all times.
REQ-016 SHALL assert issue only when dest_write=1 or when the instruction has no dest; issue with dest_write=0 SHALL still advance but is qualified externally (issue is not gated by dest_write).
REQ-017 RUN -> BR_WAIT SHALL occur on the clock edge where issue & is_branch; br_stall_count SHALL load BR_STALL_INIT on that edge.
REQ-018 In BR_WAIT, br_stall_count SHALL decrement by 1 per cycle with mem_miss=0, saturating at 0; mem_miss=1 SHALL hold it.
REQ-019 BR_WAIT SHALL exit on br_resolved regardless of mem_miss: br_taken=1 -> FLUSH, br_taken=0 -> RUN; br_stall_count SHALL clear to 0 on exit.
REQ-020 FLUSH SHALL last exactly one cycle, then RUN; flush SHALL be a registered output equal to (state==FLUSH).
REQ-021 br_resolved in RUN or FLUSH SHALL be ignored.
REQ-022 stall SHALL equal (state!=RUN) | (valid_in & !issue).
REQ-023 stall_cycles SHALL increment by 1 each cycle stall=1, saturating at 16'hFFFF (no wrap).
REQ-024 issue and is_branch with br_resolved in the same cycle SHALL enter BR_WAIT (resolution belongs to an older branch, ignored per REQ-021).

Reset
REQ-025 reset=1 SHALL immediately force state=RUN, br_stall_count=0, flush=0, stall_cycles=0, and issue=0, independent of clk.
REQ-026 Reset asserted mid-BR_WAIT or mid-FLUSH SHALL abandon the branch; first post-reset cycle SHALL be RUN with no flush.

Structure
REQ-027 lc3b_reg and a new enum issue_state_t {RUN, BR_WAIT, FLUSH} SHALL live in package lc3b_types.
REQ-028 The saturating 16-bit statistic SHALL be a sub-module sat_counter16 (inputs clk, reset, inc; output count).
REQ-029 All other logic SHALL be in issue_hazard_ctrl; no memories.

Verification
REQ-030 Reset then valid_in=1, src1=R2 used, sb_ready=8'hFF, dest=R3 -> issue=1, issue_dest=3, stall=0 same cycle.
REQ-031 sb_ready=8'hFB, src1=R2 used -> issue=0, stall=1, stall_cycles increments 1/cycle; set sb_ready[2]=1 -> issue=1 that cycle.
REQ-032 Issue branch, mem_miss=0 for 4 cycles -> br_stall_count 3,2,1,0,0, stall=1; br_resolved=1,br_taken=1 -> flush=1 next cycle only, then RUN.
REQ-033 Issue branch, mem_miss=1 for 2 cycles then br_resolved=1,br_taken=0 -> count holds at 3, returns to RUN with count 0, flush never asserted.
REQ-034 Force stall for 65540 cycles -> stall_cycles = 16'hFFFF, no wrap.
REQ-035 Assert reset asynchronously mid-BR_WAIT (between edges) -> state RUN, outputs zero immediately, flush=0 after release.
